// File: rtl/sram_responder_if.sv
// CPU <-> memory-responder bus for the SLC-3 SRAM port.
// The CPU side drives address, strobes and write data; the responder returns read data and status.
interface sram_responder_if;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic [15:0] Data_from_SRAM;
    logic        Rd_Valid;
    logic        Init_Done;
    logic        Access_Err;

    modport master (
        output ADDR, Data_to_SRAM, OE, WE,
        input  Data_from_SRAM, Rd_Valid, Init_Done, Access_Err
    );

    modport slave (
        input  ADDR, Data_to_SRAM, OE, WE,
        output Data_from_SRAM, Rd_Valid, Init_Done, Access_Err
    );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed on-chip RAM answering active-low OE/WE strobes with fixed-latency registered reads.
// A clear sweep after every reset fills the array with INIT_VALUE before the bus is served.
module sram_responder #(
    parameter int          ADDR_W     = 10,
    parameter int          READ_LAT   = 2,
    parameter logic [15:0] INIT_VALUE = 16'h0000
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [15:0]         r_mem [DEPTH];

    logic [READ_LAT-1:0] r_pipe_vld;
    logic [15:0]         r_pipe_dat [READ_LAT];

    logic [15:0]         r_data_out;
    logic                r_rd_valid;
    logic                r_init_done;
    logic                r_access_err;

    logic                w_oe;
    logic                w_we;
    logic                w_in_range;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [15:0]         w_mem_wdata;
    logic                w_rd_issue;
    logic [15:0]         w_rd_data;
    logic                w_err;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    assign w_oe       = ~bus.OE;
    assign w_we       = ~bus.WE;
    assign w_in_range = (bus.ADDR[15:ADDR_W] == {(16-ADDR_W){1'b0}});

    // State register and sweep counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_INIT;
            r_cnt   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: leave INIT on the edge that clears the last word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = (r_cnt == {ADDR_W{1'b1}}) ? ST_SERVE : ST_INIT;
            ST_SERVE: w_state_nxt = ST_SERVE;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    // Per-state datapath controls; bus strobes are ignored entirely while sweeping
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt;
        w_mem_wdata = INIT_VALUE;
        w_rd_issue  = 1'b0;
        w_rd_data   = 16'h0000;
        w_err       = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_mem_we  = 1'b1;
                w_cnt_nxt = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            ST_SERVE: begin
                w_mem_addr  = bus.ADDR[ADDR_W-1:0];
                w_mem_wdata = bus.Data_to_SRAM;
                w_mem_we    = w_we & w_in_range;
                // A simultaneous OE/WE is treated as a write only; out-of-range reads return zero
                w_rd_issue  = w_oe & ~w_we;
                w_rd_data   = w_in_range ? r_mem[bus.ADDR[ADDR_W-1:0]] : 16'h0000;
                w_err       = ((w_oe | w_we) & ~w_in_range) | (w_oe & w_we);
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Memory array write port (sweep or CPU write)
    always_ff @(posedge Clk) begin
        if (!Reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read pipeline: stage 0 captures the array at the sampling edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pipe_vld <= {READ_LAT{1'b0}};
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_dat[i] <= 16'h0000;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_dat[0] <= w_rd_data;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    // Output registers; read data holds until the next result retires
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_data_out   <= 16'h0000;
            r_rd_valid   <= 1'b0;
            r_init_done  <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_rd_valid   <= r_pipe_vld[READ_LAT-1];
            if (r_pipe_vld[READ_LAT-1]) begin
                r_data_out <= r_pipe_dat[READ_LAT-1];
            end
            r_init_done  <= (w_state_nxt == ST_SERVE);
            r_access_err <= w_err;
        end
    end

    assign bus.Data_from_SRAM = r_data_out;
    assign bus.Rd_Valid       = r_rd_valid;
    assign bus.Init_Done      = r_init_done;
    assign bus.Access_Err     = r_access_err;
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus pushes expected read results,
// a negedge monitor pops them when Rd_Valid appears and checks data and arrival cycle.
module tb_sram_responder;
    localparam int LAT = 2;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   rel;
    exp_t sb [$];

    sram_responder_if bus ();

    sram_responder #(
        .ADDR_W    (10),
        .READ_LAT  (LAT),
        .INIT_VALUE(16'h0000)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every Rd_Valid must match the oldest outstanding read, on its due cycle
    always @(negedge Clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_read: no Rd_Valid by cycle %0d, expected data %h", sb[0].due, sb[0].data);
            void'(sb.pop_front());
        end
        if (bus.Rd_Valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rd_valid: got data %h at cycle %0d, expected no read", bus.Data_from_SRAM, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.Data_from_SRAM !== e.data || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d",
                             bus.Data_from_SRAM, cyc, e.data, e.due);
                end
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic exp_err);
        bus.ADDR = a; bus.Data_to_SRAM = d; bus.WE = 1'b0; bus.OE = 1'b1;
        @(negedge Clk);
        chk("wr_access_err", {31'd0, bus.Access_Err}, {31'd0, exp_err});
        bus.WE = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input logic exp_err);
        exp_t e;
        bus.ADDR = a; bus.OE = 1'b0; bus.WE = 1'b1;
        e.data = exp;
        e.due  = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge Clk);
        chk("rd_access_err", {31'd0, bus.Access_Err}, {31'd0, exp_err});
        bus.OE = 1'b1;
    endtask

    task automatic wait_init(input int r);
        while (bus.Init_Done !== 1'b1 && (cyc - r) < 2000) @(negedge Clk);
        chk("init_length", cyc - r, 32'd1024);
    endtask

    task automatic drain();
        int t0;
        t0 = cyc;
        while (sb.size() > 0 && (cyc - t0) < 20) @(negedge Clk);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        Reset = 1'b1;
        bus.ADDR = 16'h0000; bus.Data_to_SRAM = 16'h0000; bus.OE = 1'b1; bus.WE = 1'b1;
        @(negedge Clk);
        chk("reset_data", {16'd0, bus.Data_from_SRAM}, 32'h0);
        chk("reset_rd_valid", {31'd0, bus.Rd_Valid}, 32'h0);
        chk("reset_init_done", {31'd0, bus.Init_Done}, 32'h0);
        chk("reset_access_err", {31'd0, bus.Access_Err}, 32'h0);
        Reset = 1'b0;
        rel = cyc;
        wait_init(rel);

        // Freshly cleared array
        rd(16'h0000, 16'h0000, 1'b0);
        rd(16'h01FF, 16'h0000, 1'b0);
        rd(16'h03FF, 16'h0000, 1'b0);
        drain();

        // Write then read on the very next edge
        wr(16'h0005, 16'hBEEF, 1'b0);
        rd(16'h0005, 16'hBEEF, 1'b0);
        drain();

        // Back-to-back reads return in order on consecutive cycles
        wr(16'h0010, 16'h1111, 1'b0);
        wr(16'h0011, 16'h2222, 1'b0);
        wr(16'h0012, 16'h3333, 1'b0);
        rd(16'h0010, 16'h1111, 1'b0);
        rd(16'h0011, 16'h2222, 1'b0);
        rd(16'h0012, 16'h3333, 1'b0);
        drain();
        repeat (3) @(negedge Clk);
        chk("data_hold", {16'd0, bus.Data_from_SRAM}, 32'h3333);

        // Out-of-range write is dropped (would alias onto 0x000), out-of-range read returns zero
        wr(16'h0400, 16'h7777, 1'b1);
        @(negedge Clk);
        chk("err_pulse_width", {31'd0, bus.Access_Err}, 32'h0);
        rd(16'h0000, 16'h0000, 1'b0);
        rd(16'h8005, 16'h0000, 1'b1);
        drain();

        // OE and WE both low: write lands, no read, error flagged
        bus.ADDR = 16'h0020; bus.Data_to_SRAM = 16'hA5A5; bus.OE = 1'b0; bus.WE = 1'b0;
        @(negedge Clk);
        chk("both_low_err", {31'd0, bus.Access_Err}, 32'h1);
        bus.OE = 1'b1; bus.WE = 1'b1;
        repeat (4) @(negedge Clk);
        rd(16'h0020, 16'hA5A5, 1'b0);
        drain();

        // Reset one cycle after a read is sampled: result discarded
        bus.ADDR = 16'h0020; bus.OE = 1'b0;
        @(negedge Clk);
        bus.OE = 1'b1;
        Reset = 1'b1;
        @(negedge Clk);
        chk("midread_reset_data", {16'd0, bus.Data_from_SRAM}, 32'h0);
        chk("midread_reset_init_done", {31'd0, bus.Init_Done}, 32'h0);
        Reset = 1'b0;
        repeat (500) @(negedge Clk);

        // Reset at sweep count 500, then strobes during the restarted sweep are ignored
        Reset = 1'b1;
        @(negedge Clk);
        chk("midsweep_reset_init_done", {31'd0, bus.Init_Done}, 32'h0);
        Reset = 1'b0;
        rel = cyc;
        repeat (100) @(negedge Clk);
        bus.ADDR = 16'h0050; bus.Data_to_SRAM = 16'hDEAD; bus.OE = 1'b0; bus.WE = 1'b0;
        @(negedge Clk);
        chk("init_no_err", {31'd0, bus.Access_Err}, 32'h0);
        bus.OE = 1'b1; bus.WE = 1'b1;
        wait_init(rel);
        chk("init_data_idle", {16'd0, bus.Data_from_SRAM}, 32'h0);

        rd(16'h0050, 16'h0000, 1'b0);
        rd(16'h0005, 16'h0000, 1'b0);
        rd(16'h0012, 16'h0000, 1'b0);
        drain();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
